// File: rtl/irrigation_pkg.sv
// Shared types for the irrigation zone scheduler.
// FSM state encoding and watering mode encoding.
package irrigation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IRRIGATE = 3'd1,
    ST_CLEAN    = 3'd2,
    ST_ERROR    = 3'd3
  } state_t;

  typedef enum logic {
    MODE_SPR  = 1'b0,
    MODE_DRIP = 1'b1
  } mode_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, with wrap.
// Ports: req (N), ptr (start index) -> valid, idx.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int j;

  // Scan from the farthest offset down so the
  // nearest requester is the last to overwrite.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j[IW-1:0]]) begin
        valid = 1'b1;
        idx   = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Multi-zone irrigation scheduler: one zone at a time, tank level model,
// fill valve, post-fertiliser cleaning, conflict error. Ports: clock,
// reset(n), tick, req_spr/drip/fert -> zone_valve, active_zone,
// fill_valve, level, low, critical, cleaning, erro, state.
module irrigation_zone_scheduler
  import irrigation_pkg::*;
#(
  parameter  int N_ZONES     = 4,
  parameter  int LEVEL_W     = 8,
  parameter  int LEVEL_MAX   = 200,
  parameter  int LOW_THR     = 60,
  parameter  int CRIT_THR    = 20,
  parameter  int FILL_STEP   = 4,
  parameter  int SPR_STEP    = 3,
  parameter  int DRIP_STEP   = 1,
  parameter  int DURATION    = 16,
  parameter  int CLEAN_TICKS = 8,
  localparam int ZW          = $clog2(N_ZONES)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic [N_ZONES-1:0] req_spr,
  input  logic [N_ZONES-1:0] req_drip,
  input  logic [N_ZONES-1:0] req_fert,
  output logic [N_ZONES-1:0] zone_valve,
  output logic [ZW-1:0]      active_zone,
  output logic               fill_valve,
  output logic [LEVEL_W-1:0] level,
  output logic               low,
  output logic               critical,
  output logic               cleaning,
  output logic               erro,
  output logic [2:0]         state
);

  localparam int CNT_MAX =
    (DURATION > CLEAN_TICKS) ? DURATION : CLEAN_TICKS;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int SW = LEVEL_W + 2;

  localparam logic [LEVEL_W-1:0] L_MAX  = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] L_LOW  = LEVEL_W'(LOW_THR);
  localparam logic [LEVEL_W-1:0] L_CRIT = LEVEL_W'(CRIT_THR);

  localparam logic signed [SW-1:0] S_FILL = SW'(FILL_STEP);
  localparam logic signed [SW-1:0] S_SPR  = SW'(SPR_STEP);
  localparam logic signed [SW-1:0] S_DRIP = SW'(DRIP_STEP);
  localparam logic signed [SW-1:0] S_MAX  = SW'(LEVEL_MAX);

  localparam logic [CW-1:0] C_DUR  = CW'(DURATION);
  localparam logic [CW-1:0] C_CLN  = CW'(CLEAN_TICKS);
  localparam logic [ZW-1:0] Z_LAST = ZW'(N_ZONES - 1);

  state_t               state_q, state_d;
  mode_t                mode_q, mode_d;
  logic                 fert_q, fert_d;
  logic [ZW-1:0]        zone_q, zone_d;
  logic [ZW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic                 fill_q, fill_d;
  logic [N_ZONES-1:0]   valve_q, valve_d;

  logic                 conflict;
  logic                 cand_valid;
  logic [ZW-1:0]        cand_idx;
  logic signed [SW-1:0] lvl_sum;
  logic [LEVEL_W-1:0]   lvl_new;
  logic [CW-1:0]        cnt_inc;
  logic [ZW-1:0]        zone_nxt;
  logic                 serving;

  assign conflict = |(req_spr & req_drip);
  assign cnt_inc  = cnt_q + 1'b1;
  assign zone_nxt = (zone_q == Z_LAST) ? '0 : zone_q + 1'b1;

  rr_arbiter #(
    .N (N_ZONES)
  ) u_arb (
    .req   (req_spr | req_drip),
    .ptr   (ptr_q),
    .valid (cand_valid),
    .idx   (cand_idx)
  );

  // Fill and drain net together, then clamp to [0, LEVEL_MAX].
  always_comb begin
    lvl_sum = SW'(level_q);
    if (fill_q)
      lvl_sum = lvl_sum + S_FILL;
    if (state_q == ST_IRRIGATE)
      lvl_sum = lvl_sum -
        ((mode_q == MODE_SPR) ? S_SPR : S_DRIP);
    if (lvl_sum[SW-1])
      lvl_new = '0;
    else if (lvl_sum > S_MAX)
      lvl_new = L_MAX;
    else
      lvl_new = lvl_sum[LEVEL_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    fert_d  = fert_q;
    zone_d  = zone_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    fill_d  = fill_q;
    valve_d = '0;
    if (conflict) begin
      state_d = ST_ERROR;
      fill_d  = 1'b0;
    end else if (tick) begin
      // Valve decision uses the level just written.
      if (state_q != ST_ERROR) begin
        level_d = lvl_new;
        if (lvl_new <= L_LOW)
          fill_d = 1'b1;
        else if (lvl_new >= L_MAX)
          fill_d = 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (cand_valid && level_q > L_CRIT) begin
            state_d = ST_IRRIGATE;
            zone_d  = cand_idx;
            mode_d  = req_spr[cand_idx] ? MODE_SPR
                                        : MODE_DRIP;
            fert_d  = req_fert[cand_idx];
            cnt_d   = '0;
          end
        end
        ST_IRRIGATE: begin
          cnt_d = cnt_inc;
          if (lvl_new <= L_CRIT) begin
            state_d = ST_IDLE;
            ptr_d   = zone_nxt;
          end else if (cnt_inc == C_DUR) begin
            state_d = fert_q ? ST_CLEAN : ST_IDLE;
            ptr_d   = zone_nxt;
            cnt_d   = '0;
          end
        end
        ST_CLEAN: begin
          cnt_d = cnt_inc;
          if (cnt_inc == C_CLN) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_ERROR: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
    if (state_d == ST_IRRIGATE || state_d == ST_CLEAN)
      valve_d = N_ZONES'(1) << zone_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SPR;
      fert_q  <= 1'b0;
      zone_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      level_q <= L_MAX;
      fill_q  <= 1'b0;
      valve_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      fert_q  <= fert_d;
      zone_q  <= zone_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fill_q  <= fill_d;
      valve_q <= valve_d;
    end
  end

  assign serving     = (state_q == ST_IRRIGATE) ||
                       (state_q == ST_CLEAN);
  assign active_zone = serving ? zone_q : '0;
  assign zone_valve  = valve_q;
  assign fill_valve  = fill_q;
  assign level       = level_q;
  assign low         = (level_q <= L_LOW);
  assign critical    = (level_q <= L_CRIT);
  assign cleaning    = (state_q == ST_CLEAN);
  assign erro        = (state_q == ST_ERROR);
  assign state       = state_q;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Bench for irrigation_zone_scheduler: vector table, corner sequences,
// random stimulus against a behavioural tank/scheduler model.
module tb_irrigation_zone_scheduler;

  localparam int M_MAX  = 200;
  localparam int M_LOW  = 60;
  localparam int M_CRIT = 20;
  localparam int M_DUR  = 16;
  localparam int M_CLN  = 8;

  logic       clock;
  logic       reset;
  logic       tick;
  logic [3:0] req_spr, req_drip, req_fert;

  logic [3:0] zone_valve, d_zone_valve;
  logic [1:0] active_zone, d_active_zone;
  logic       fill_valve, d_fill_valve;
  logic [7:0] level, d_level;
  logic       low, d_low, critical, d_critical;
  logic       cleaning, d_cleaning, erro, d_erro;
  logic [2:0] state, d_state;

  int checks = 0;
  int errors = 0;

  irrigation_zone_scheduler u_dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .req_spr     (req_spr),
    .req_drip    (req_drip),
    .req_fert    (req_fert),
    .zone_valve  (zone_valve),
    .active_zone (active_zone),
    .fill_valve  (fill_valve),
    .level       (level),
    .low         (low),
    .critical    (critical),
    .cleaning    (cleaning),
    .erro        (erro),
    .state       (state)
  );

  // Same block with no refill, so the tank can reach critical.
  irrigation_zone_scheduler #(
    .FILL_STEP (0)
  ) u_dry (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .req_spr     (req_spr),
    .req_drip    (req_drip),
    .req_fert    (req_fert),
    .zone_valve  (d_zone_valve),
    .active_zone (d_active_zone),
    .fill_valve  (d_fill_valve),
    .level       (d_level),
    .low         (d_low),
    .critical    (d_critical),
    .cleaning    (d_cleaning),
    .erro        (d_erro),
    .state       (d_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  task automatic run(input bit t, input int n);
    for (int i = 0; i < n; i++) begin
      tick = t;
      @(posedge clock);
      #1;
    end
    tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b0;
    tick     = 1'b0;
    req_spr  = '0;
    req_drip = '0;
    req_fert = '0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_level", level, 200);
    chk("rst_valve", zone_valve, 0);
    chk("rst_fill", fill_valve, 0);
    chk("rst_zone", active_zone, 0);
    chk("rst_erro", erro, 0);
    chk("rst_clean", cleaning, 0);
    chk("rst_low", low, 0);
    chk("rst_crit", critical, 0);
    chk("rst_dry_level", d_level, 200);
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  // Behavioural model: st 0 idle, 1 watering, 2 cleaning, 3 error.
  typedef struct {
    int st;
    int lvl;
    bit fill;
    int zone;
    int ptr;
    bit drip;
    bit fert;
    int left;
  } mdl_t;

  function automatic mdl_t mreset();
    mdl_t m;
    m.st = 0; m.lvl = M_MAX; m.fill = 0; m.zone = 0;
    m.ptr = 0; m.drip = 0; m.fert = 0; m.left = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m,
                                 logic [3:0] s,
                                 logic [3:0] d,
                                 logic [3:0] f,
                                 bit t,
                                 int fstep);
    int nl;
    int z;
    if ((s & d) != 4'b0) begin
      m.st = 3;
      m.fill = 0;
      return m;
    end
    if (!t) return m;
    if (m.st == 3) begin
      m.st = 0;
      return m;
    end
    nl = m.lvl + (m.fill ? fstep : 0);
    if (m.st == 1) nl -= (m.drip ? 1 : 3);
    if (nl < 0) nl = 0;
    if (nl > M_MAX) nl = M_MAX;
    case (m.st)
      0: begin
        for (int k = 0; k < 4; k++) begin
          z = (m.ptr + k) % 4;
          if (s[z] || d[z]) begin
            if (m.lvl > M_CRIT) begin
              m.st = 1; m.zone = z; m.drip = !s[z];
              m.fert = f[z]; m.left = M_DUR;
            end
            break;
          end
        end
      end
      1: begin
        m.left--;
        if (nl <= M_CRIT) begin
          m.st = 0; m.ptr = (m.zone + 1) % 4;
        end else if (m.left == 0) begin
          m.ptr = (m.zone + 1) % 4;
          if (m.fert) begin
            m.st = 2; m.left = M_CLN;
          end else m.st = 0;
        end
      end
      2: begin
        m.left--;
        if (m.left == 0) m.st = 0;
      end
      default: m.st = 0;
    endcase
    m.lvl = nl;
    if (nl <= M_LOW) m.fill = 1;
    else if (nl >= M_MAX) m.fill = 0;
    return m;
  endfunction

  task automatic cmp(input string tag, input mdl_t m,
                     input logic [2:0] st, input logic [7:0] lv,
                     input logic [3:0] zv, input logic fl,
                     input logic [1:0] az, input logic lo,
                     input logic cr, input logic cl,
                     input logic er);
    bit srv;
    srv = (m.st == 1) || (m.st == 2);
    chk({tag, "_state"}, st, m.st);
    chk({tag, "_level"}, lv, m.lvl);
    chk({tag, "_valve"}, zv, srv ? (1 << m.zone) : 0);
    chk({tag, "_fill"}, fl, m.fill);
    chk({tag, "_zone"}, az, srv ? m.zone : 0);
    chk({tag, "_low"}, lo, m.lvl <= M_LOW);
    chk({tag, "_crit"}, cr, m.lvl <= M_CRIT);
    chk({tag, "_clean"}, cl, m.st == 2);
    chk({tag, "_erro"}, er, m.st == 3);
  endtask

  typedef struct {
    logic [3:0] spr;
    logic [3:0] drip;
    logic [3:0] fert;
    bit         tk;
    int         n;
    int         st;
    int         lvl;
    logic [3:0] valve;
    int         az;
    bit         fl;
  } vec_t;

  vec_t vt[12];
  int   rr_exp[5];
  int   nfound;
  int   prev_st;
  mdl_t m, dm;

  initial begin
    reset    = 1'b0;
    tick     = 1'b0;
    req_spr  = '0;
    req_drip = '0;
    req_fert = '0;

    vt[0]  = '{4'b0100, 4'b0000, 4'b0000, 1, 1,  1, 200, 4'b0100, 2, 0};
    vt[1]  = '{4'b0100, 4'b0000, 4'b0000, 1, 15, 1, 155, 4'b0100, 2, 0};
    vt[2]  = '{4'b0100, 4'b0000, 4'b0000, 1, 1,  0, 152, 4'b0000, 0, 0};
    vt[3]  = '{4'b0000, 4'b0010, 4'b0010, 1, 1,  1, 152, 4'b0010, 1, 0};
    vt[4]  = '{4'b0000, 4'b0010, 4'b0010, 1, 8,  1, 144, 4'b0010, 1, 0};
    vt[5]  = '{4'b1000, 4'b1010, 4'b0010, 0, 1,  3, 144, 4'b0000, 0, 0};
    vt[6]  = '{4'b0000, 4'b0010, 4'b0010, 0, 3,  3, 144, 4'b0000, 0, 0};
    vt[7]  = '{4'b0000, 4'b0010, 4'b0010, 1, 1,  0, 144, 4'b0000, 0, 0};
    vt[8]  = '{4'b0000, 4'b0010, 4'b0010, 1, 1,  1, 144, 4'b0010, 1, 0};
    vt[9]  = '{4'b0000, 4'b0010, 4'b0010, 1, 16, 2, 128, 4'b0010, 1, 0};
    vt[10] = '{4'b0000, 4'b0000, 4'b0000, 1, 7,  2, 128, 4'b0010, 1, 0};
    vt[11] = '{4'b0000, 4'b0000, 4'b0000, 1, 1,  0, 128, 4'b0000, 0, 0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      req_spr  = vt[i].spr;
      req_drip = vt[i].drip;
      req_fert = vt[i].fert;
      run(vt[i].tk, vt[i].n);
      chk($sformatf("vec%0d_state", i), state, vt[i].st);
      chk($sformatf("vec%0d_level", i), level, vt[i].lvl);
      chk($sformatf("vec%0d_valve", i), zone_valve, vt[i].valve);
      chk($sformatf("vec%0d_zone", i), active_zone, vt[i].az);
      chk($sformatf("vec%0d_fill", i), fill_valve, vt[i].fl);
    end

    // Round robin with every zone asking.
    rr_exp = '{0, 1, 2, 3, 0};
    do_reset();
    req_spr = 4'b1111;
    nfound  = 0;
    prev_st = 0;
    for (int c = 0; c < 300 && nfound < 5; c++) begin
      tick = 1'b1;
      @(posedge clock);
      #1;
      if (state == 3'd1 && prev_st != 1) begin
        chk($sformatf("rr_order%0d", nfound),
            active_zone, rr_exp[nfound]);
        nfound++;
      end
      prev_st = int'(state);
    end
    tick = 1'b0;
    chk("rr_sessions", nfound, 5);
    chk("pre_reset_irr", state, 1);
    do_reset();

    // Fill valve thresholds, request drop, critical abort.
    req_spr = 4'b0001;
    run(1, 49);
    chk("fill_l62_level", level, 62);
    chk("fill_l62_fill", fill_valve, 0);
    run(1, 1);
    chk("fill_open_level", level, 59);
    chk("fill_open_fill", fill_valve, 1);
    run(1, 2);
    chk("fill_restart_level", level, 64);
    run(1, 1);
    chk("fill_net_level", level, 65);
    chk("fill_net_state", state, 1);
    req_spr = 4'b0000;
    run(1, 10);
    chk("dry_l23_level", d_level, 23);
    chk("dry_l23_state", d_state, 1);
    chk("drop_keeps_state", state, 1);
    run(1, 1);
    chk("dry_abort_level", d_level, 20);
    chk("dry_abort_state", d_state, 0);
    chk("dry_abort_crit", d_critical, 1);
    chk("dry_abort_valve", d_zone_valve, 0);
    run(1, 4);
    chk("drop_done_state", state, 0);
    chk("drop_done_level", level, 80);
    run(1, 29);
    chk("fill_near_level", level, 196);
    chk("fill_near_fill", fill_valve, 1);
    run(1, 1);
    chk("fill_close_level", level, 200);
    chk("fill_close_fill", fill_valve, 0);
    req_spr = 4'b0001;
    run(1, 10);
    chk("dry_refuse_state", d_state, 0);
    chk("dry_refuse_valve", d_zone_valve, 0);
    chk("dry_refuse_level", d_level, 20);

    // Random traffic against the model.
    do_reset();
    m  = mreset();
    dm = mreset();
    for (int c = 0; c < 2500; c++) begin
      tick = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 5) == 0) begin
        req_spr  = 4'($urandom) & 4'($urandom);
        req_drip = 4'($urandom) & ~req_spr;
        req_fert = 4'($urandom);
        if ($urandom_range(0, 29) == 0)
          req_drip = req_drip | req_spr;
      end
      m  = mstep(m, req_spr, req_drip, req_fert, tick, 4);
      dm = mstep(dm, req_spr, req_drip, req_fert, tick, 0);
      @(posedge clock);
      #1;
      cmp("rnd", m, state, level, zone_valve, fill_valve,
          active_zone, low, critical, cleaning, erro);
      cmp("rnd_dry", dm, d_state, d_level, d_zone_valve,
          d_fill_valve, d_active_zone, d_low, d_critical,
          d_cleaning, d_erro);
    end
    tick = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
